// File: rtl/axi_stream_frame_sink_pkg.sv
// Shared types and geometry helpers for the A2RT frame sink and its counters.
package axi_stream_frame_sink_pkg;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        SINK_IDLE = 2'd0,
        SINK_RECV = 2'd1,
        SINK_DONE = 2'd2
    } sink_state_t;

    localparam int DEF_PIC_WIDTH  = 800;
    localparam int DEF_PIC_HEIGHT = 600;

    function automatic int nb_pixels(input int w, input int h);
        return w * h;
    endfunction

    localparam int NB_PIXELS = nb_pixels(DEF_PIC_WIDTH, DEF_PIC_HEIGHT);

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_stream_frame_sink_if.sv
// AXI4-Stream beat bundle between the A2RT pixel source and the frame sink.
interface axi_stream_frame_sink_if #(
    parameter int WIDTH = 24
);
    logic               tvalid;
    logic [WIDTH-1:0]   tdata;
    logic [WIDTH/8-1:0] tstrb;
    logic               tlast;
    logic               tready;

    modport master (output tvalid, tdata, tstrb, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/axi_stream_frame_sink_xy_counter.sv
// Raster position counter: x wraps at the line width and carries into y;
// last flags the final pixel of the frame.
module frame_xy_counter
    import axi_stream_frame_sink_pkg::*;
#(
    parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
    parameter int PIC_HEIGHT = DEF_PIC_HEIGHT,
    parameter int XW         = cnt_bits(PIC_WIDTH),
    parameter int YW         = cnt_bits(PIC_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(PIC_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(PIC_HEIGHT - 1);

    logic [XW-1:0] x_reg, x_next;
    logic [YW-1:0] y_reg, y_next;

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (clear) begin
            x_next = '0;
            y_next = '0;
        end else if (inc) begin
            if (x_reg == X_MAX) begin
                x_next = '0;
                y_next = (y_reg == Y_MAX) ? '0 : y_reg + 1'b1;
            end else begin
                x_next = x_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    assign x    = x_reg;
    assign y    = y_reg;
    assign last = (x_reg == X_MAX) && (y_reg == Y_MAX);

endmodule

// File: rtl/axi_stream_frame_sink.sv
// AXI4-Stream frame receiver: checks framing, sums pixels and mirrors each
// accepted beat onto a linear write port, one frame per enable.
module axi_stream_frame_sink
    import axi_stream_frame_sink_pkg::*;
#(
    parameter int WIDTH        = $bits(pixel_t),
    parameter int PIC_WIDTH    = DEF_PIC_WIDTH,
    parameter int PIC_HEIGHT   = DEF_PIC_HEIGHT,
    parameter int STALL_PERIOD = 0,
    parameter int ADDR_W       = 19
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic                  enable_i,
    axi_stream_frame_sink_if.slave s_axis,
    output logic                  wr_en_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [WIDTH-1:0]      wr_data_o,
    output logic                  frame_done_o,
    output logic                  frame_ok_o,
    output logic                  err_tlast_early_o,
    output logic                  err_tlast_missing_o,
    output logic                  err_strb_o,
    output logic [31:0]           checksum_o,
    output logic [ADDR_W-1:0]     pixel_cnt_o
);

    localparam int XW = cnt_bits(PIC_WIDTH);
    localparam int YW = cnt_bits(PIC_HEIGHT);
    localparam int SB = WIDTH / 8;

    sink_state_t state_reg, state_next;
    logic        clear_frame;
    logic        accept;
    logic        stall_now;
    logic        last_pix;
    logic        strb_bad;
    logic [XW-1:0] x_cur;
    logic [YW-1:0] y_cur;
    logic [ADDR_W-1:0] lin_addr;
    logic [SB-1:0] byte_missing;

    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [WIDTH-1:0]  wr_data_reg;
    logic [31:0]       checksum_reg;
    logic [ADDR_W-1:0] pixel_cnt_reg;
    logic              err_early_reg, err_missing_reg, err_strb_reg;

    // Ready is a pure state decode so it never combinationally follows tvalid.
    assign s_axis.tready = (state_reg == SINK_RECV) && !stall_now;
    assign accept        = s_axis.tvalid && s_axis.tready;

    generate
        for (genvar gi = 0; gi < SB; gi++) begin : g_strb
            assign byte_missing[gi] = ~s_axis.tstrb[gi];
        end
    endgenerate
    assign strb_bad = |byte_missing;

    generate
        if (STALL_PERIOD > 0) begin : g_stall
            localparam int SW = cnt_bits(STALL_PERIOD);
            localparam logic [SW-1:0] STALL_MAX = SW'(STALL_PERIOD - 1);
            logic [SW-1:0] stall_cnt_reg;

            // Free-runs over every RECV cycle, restarting at each frame start.
            always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
                if (!s_axis_aresetn) begin
                    stall_cnt_reg <= '0;
                end else if (clear_frame) begin
                    stall_cnt_reg <= '0;
                end else if (state_reg == SINK_RECV) begin
                    stall_cnt_reg <= (stall_cnt_reg == STALL_MAX) ? '0 : stall_cnt_reg + 1'b1;
                end
            end
            assign stall_now = (stall_cnt_reg == STALL_MAX);
        end else begin : g_no_stall
            assign stall_now = 1'b0;
        end
    endgenerate

    frame_xy_counter #(
        .PIC_WIDTH  (PIC_WIDTH),
        .PIC_HEIGHT (PIC_HEIGHT),
        .XW         (XW),
        .YW         (YW)
    ) u_xy (
        .clk   (s_axis_aclk),
        .rst_n (s_axis_aresetn),
        .clear (clear_frame),
        .inc   (accept),
        .x     (x_cur),
        .y     (y_cur),
        .last  (last_pix)
    );

    assign lin_addr = ADDR_W'(y_cur) * ADDR_W'(PIC_WIDTH) + ADDR_W'(x_cur);

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_reg <= SINK_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        clear_frame = 1'b0;
        case (state_reg)
            SINK_IDLE: begin
                if (enable_i) begin
                    state_next  = SINK_RECV;
                    clear_frame = 1'b1;
                end
            end
            SINK_RECV: begin
                // Either the geometric end or an early tlast closes the frame.
                if (accept && (last_pix || s_axis.tlast)) begin
                    state_next = SINK_DONE;
                end
            end
            SINK_DONE: begin
                if (enable_i) begin
                    state_next  = SINK_RECV;
                    clear_frame = 1'b1;
                end else begin
                    state_next = SINK_IDLE;
                end
            end
            default: state_next = SINK_IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            checksum_reg    <= '0;
            pixel_cnt_reg   <= '0;
            err_early_reg   <= 1'b0;
            err_missing_reg <= 1'b0;
            err_strb_reg    <= 1'b0;
        end else begin
            wr_en_reg <= accept;
            if (accept) begin
                wr_addr_reg <= lin_addr;
                wr_data_reg <= s_axis.tdata;
            end
            if (clear_frame) begin
                checksum_reg    <= '0;
                pixel_cnt_reg   <= '0;
                err_early_reg   <= 1'b0;
                err_missing_reg <= 1'b0;
                err_strb_reg    <= 1'b0;
            end else if (accept) begin
                checksum_reg  <= checksum_reg + 32'(s_axis.tdata);
                pixel_cnt_reg <= pixel_cnt_reg + 1'b1;
                if (strb_bad)
                    err_strb_reg <= 1'b1;
                if (last_pix && !s_axis.tlast)
                    err_missing_reg <= 1'b1;
                if (!last_pix && s_axis.tlast)
                    err_early_reg <= 1'b1;
            end
        end
    end

    assign wr_en_o             = wr_en_reg;
    assign wr_addr_o           = wr_addr_reg;
    assign wr_data_o           = wr_data_reg;
    assign checksum_o          = checksum_reg;
    assign pixel_cnt_o         = pixel_cnt_reg;
    assign err_tlast_early_o   = err_early_reg;
    assign err_tlast_missing_o = err_missing_reg;
    assign err_strb_o          = err_strb_reg;
    assign frame_done_o        = (state_reg == SINK_DONE);
    assign frame_ok_o          = (state_reg == SINK_DONE) &&
                                 !(err_early_reg || err_missing_reg || err_strb_reg);

endmodule

// File: tb/tb_axi_stream_frame_sink.sv
// Directed bench for the frame sink on a 4x3 frame: one sink unthrottled,
// one with STALL_PERIOD=3, driven from a vector table plus corner sequences.
module tb_axi_stream_frame_sink;

    logic tb_clk = 1'b0;
    logic tb_reset_n = 1'b1;
    always #5 tb_clk = ~tb_clk;

    logic [1:0]  enable;
    logic [1:0]  wr_en, frame_done, frame_ok, e_early, e_miss, e_strb, tready;
    logic [3:0]  wr_addr [2];
    logic [23:0] wr_data [2];
    logic [31:0] checksum [2];
    logic [3:0]  pixel_cnt [2];

    axi_stream_frame_sink_if #(.WIDTH(24)) if0 ();
    axi_stream_frame_sink_if #(.WIDTH(24)) if1 ();
    assign tready[0] = if0.tready;
    assign tready[1] = if1.tready;

    axi_stream_frame_sink #(
        .WIDTH(24), .PIC_WIDTH(4), .PIC_HEIGHT(3), .STALL_PERIOD(0), .ADDR_W(4)
    ) u0 (
        .s_axis_aclk(tb_clk), .s_axis_aresetn(tb_reset_n), .enable_i(enable[0]),
        .s_axis(if0), .wr_en_o(wr_en[0]), .wr_addr_o(wr_addr[0]), .wr_data_o(wr_data[0]),
        .frame_done_o(frame_done[0]), .frame_ok_o(frame_ok[0]),
        .err_tlast_early_o(e_early[0]), .err_tlast_missing_o(e_miss[0]),
        .err_strb_o(e_strb[0]), .checksum_o(checksum[0]), .pixel_cnt_o(pixel_cnt[0])
    );

    axi_stream_frame_sink #(
        .WIDTH(24), .PIC_WIDTH(4), .PIC_HEIGHT(3), .STALL_PERIOD(3), .ADDR_W(4)
    ) u1 (
        .s_axis_aclk(tb_clk), .s_axis_aresetn(tb_reset_n), .enable_i(enable[1]),
        .s_axis(if1), .wr_en_o(wr_en[1]), .wr_addr_o(wr_addr[1]), .wr_data_o(wr_data[1]),
        .frame_done_o(frame_done[1]), .frame_ok_o(frame_ok[1]),
        .err_tlast_early_o(e_early[1]), .err_tlast_missing_o(e_miss[1]),
        .err_strb_o(e_strb[1]), .checksum_o(checksum[1]), .pixel_cnt_o(pixel_cnt[1])
    );

    typedef struct {
        int w; int n; int tlast_at; int strb_at; bit toggle;
        int exp_cnt; int exp_sum; bit exp_ok; bit exp_early; bit exp_miss; bit exp_strb;
        int exp_cycles;
    } vec_t;

    typedef struct { int addr; int data; } wr_t;

    vec_t vecs [6];
    wr_t  wq0 [$];
    wr_t  wq1 [$];
    int   done_cnt [2];
    bit   ok_seen [2];
    int   total = 0;
    int   bad = 0;
    int   beat_cycles;

    always @(negedge tb_clk) begin
        for (int m = 0; m < 2; m++) begin
            if (frame_done[m] === 1'b1) begin
                done_cnt[m] = done_cnt[m] + 1;
                ok_seen[m]  = frame_ok[m];
            end
        end
        if (wr_en[0] === 1'b1) wq0.push_back('{int'(wr_addr[0]), int'(wr_data[0])});
        if (wr_en[1] === 1'b1) wq1.push_back('{int'(wr_addr[1]), int'(wr_data[1])});
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_bus(input int w, input logic v, input logic [23:0] d,
                           input logic [2:0] s, input logic l);
        if (w == 0) begin
            if0.tvalid = v; if0.tdata = d; if0.tstrb = s; if0.tlast = l;
        end else begin
            if1.tvalid = v; if1.tdata = d; if1.tstrb = s; if1.tlast = l;
        end
    endtask

    task automatic pulse_enable(input int w);
        enable[w] = 1'b1;
        @(negedge tb_clk);
        enable[w] = 1'b0;
    endtask

    // Ready is stable between edges, so sampling it at the negedge tells
    // whether the following posedge transfers the beat.
    task automatic send_beat(input int w, input logic [23:0] d, input logic [2:0] s,
                             input logic l);
        bit   got;
        logic r;
        got = 1'b0;
        set_bus(w, 1'b1, d, s, l);
        for (int c = 0; c < 20 && !got; c++) begin
            r = tready[w];
            @(negedge tb_clk);
            beat_cycles++;
            if (r === 1'b1) got = 1'b1;
        end
        chk($sformatf("beat_accept w%0d d%0d", w, d), got, 1);
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        wr_t  q [$];
        int   d0;
        v = vecs[k];
        wq0.delete();
        wq1.delete();
        d0 = done_cnt[v.w];
        pulse_enable(v.w);
        chk($sformatf("v%0d start_cnt", k), pixel_cnt[v.w], 0);
        chk($sformatf("v%0d start_sum", k), checksum[v.w], 0);
        chk($sformatf("v%0d start_errs", k), {e_early[v.w], e_miss[v.w], e_strb[v.w]}, 0);
        beat_cycles = 0;
        for (int i = 1; i <= v.n; i++) begin
            if (v.toggle) begin
                set_bus(v.w, 1'b0, 24'd0, 3'b111, 1'b0);
                @(negedge tb_clk);
            end
            if (i == v.n)
                chk($sformatf("v%0d no_early_done", k), done_cnt[v.w] - d0, 0);
            send_beat(v.w, 24'(i), (i == v.strb_at) ? 3'b011 : 3'b111, i == v.tlast_at);
        end
        set_bus(v.w, 1'b0, 24'd0, 3'b111, 1'b0);
        if (v.exp_cycles != 0)
            chk($sformatf("v%0d beat_cycles", k), beat_cycles, v.exp_cycles);
        repeat (3) @(negedge tb_clk);
        chk($sformatf("v%0d done_pulses", k), done_cnt[v.w] - d0, 1);
        chk($sformatf("v%0d frame_ok", k), ok_seen[v.w], v.exp_ok);
        chk($sformatf("v%0d pixel_cnt", k), pixel_cnt[v.w], v.exp_cnt);
        chk($sformatf("v%0d checksum", k), checksum[v.w], v.exp_sum);
        chk($sformatf("v%0d err_early", k), e_early[v.w], v.exp_early);
        chk($sformatf("v%0d err_missing", k), e_miss[v.w], v.exp_miss);
        chk($sformatf("v%0d err_strb", k), e_strb[v.w], v.exp_strb);
        if (v.w == 0) q = wq0; else q = wq1;
        chk($sformatf("v%0d n_writes", k), q.size(), v.exp_cnt);
        for (int i = 0; i < q.size() && i < v.exp_cnt; i++) begin
            chk($sformatf("v%0d wr_addr[%0d]", k, i), q[i].addr, i);
            chk($sformatf("v%0d wr_data[%0d]", k, i), q[i].data, i + 1);
        end
        $display("vec %0d: w=%0d beats=%0d cnt=%0d sum=%0d ok=%0b", k, v.w, v.n,
                 pixel_cnt[v.w], checksum[v.w], ok_seen[v.w]);
    endtask

    initial begin
        //          w  n tl  sb tg cnt sum ok ea mi st cyc
        vecs[0] = '{0, 12, 12, 0, 0, 12, 78, 1, 0, 0, 0, 12};
        vecs[1] = '{0, 12, 12, 0, 1, 12, 78, 1, 0, 0, 0, 12};
        vecs[2] = '{1, 12, 12, 0, 0, 12, 78, 1, 0, 0, 0, 0};
        vecs[3] = '{0,  5,  5, 0, 0,  5, 15, 0, 1, 0, 0, 5};
        vecs[4] = '{0, 12,  0, 2, 0, 12, 78, 0, 0, 1, 1, 12};
        vecs[5] = '{0, 12, 12, 0, 0, 12, 78, 1, 0, 0, 0, 12};

        enable = 2'b00;
        done_cnt[0] = 0; done_cnt[1] = 0;
        set_bus(0, 1'b0, 24'd0, 3'b111, 1'b0);
        set_bus(1, 1'b0, 24'd0, 3'b111, 1'b0);
        #2 tb_reset_n = 1'b0;
        repeat (2) @(negedge tb_clk);
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("rst w%0d tready", w), tready[w], 0);
            chk($sformatf("rst w%0d wr_en", w), wr_en[w], 0);
            chk($sformatf("rst w%0d done", w), frame_done[w], 0);
            chk($sformatf("rst w%0d checksum", w), checksum[w], 0);
            chk($sformatf("rst w%0d pixel_cnt", w), pixel_cnt[w], 0);
        end
        tb_reset_n = 1'b1;
        @(negedge tb_clk);
        chk("idle tready", tready[0], 0);

        run_vec(0);
        run_vec(1);

        // Throttled sink: ready pattern 1,1,0,1 from the first RECV cycle.
        pulse_enable(1);
        chk("stall c1", tready[1], 1);
        @(negedge tb_clk);
        chk("stall c2", tready[1], 1);
        @(negedge tb_clk);
        chk("stall c3", tready[1], 0);
        @(negedge tb_clk);
        chk("stall c4", tready[1], 1);
        run_vec(2);

        run_vec(3);
        run_vec(4);

        // Reset in the middle of a frame, right after the 6th beat.
        wq0.delete();
        pulse_enable(0);
        for (int i = 1; i <= 6; i++) send_beat(0, 24'(i), 3'b111, 1'b0);
        begin
            int d0;
            d0 = done_cnt[0];
            tb_reset_n = 1'b0;
            #1;
            chk("midrst wr_en", wr_en[0], 0);
            chk("midrst pixel_cnt", pixel_cnt[0], 0);
            chk("midrst checksum", checksum[0], 0);
            chk("midrst tready", tready[0], 0);
            chk("midrst errs", {e_early[0], e_miss[0], e_strb[0]}, 0);
            set_bus(0, 1'b0, 24'd0, 3'b111, 1'b0);
            repeat (2) @(negedge tb_clk);
            tb_reset_n = 1'b1;
            repeat (2) @(negedge tb_clk);
            chk("midrst no_done", done_cnt[0] - d0, 0);
            $display("mid-frame reset: pixel_cnt=%0d done=%0d", pixel_cnt[0], done_cnt[0] - d0);
        end
        run_vec(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
